// File: rtl/vga_timing_core_if.sv
// Display timing bundle: enable in, pixel strobe, coordinates, syncs and frame markers out.
interface vga_timing_core_if #(
  parameter int unsigned COORD_W = 10
);
  logic               enable;
  logic               pix_ce;
  logic [COORD_W-1:0] pixel_column;
  logic [COORD_W-1:0] pixel_row;
  logic               horiz_sync;
  logic               vert_sync;
  logic               video_on;
  logic               line_start;
  logic               frame_start;
  logic               vblank;
  logic [15:0]        frame_count;

  // Timing generator side
  modport master (
    input  enable,
    output pix_ce, pixel_column, pixel_row, horiz_sync, vert_sync,
           video_on, line_start, frame_start, vblank, frame_count
  );

  // Consumer side (icon/colorizer, bot-update logic)
  modport slave (
    output enable,
    input  pix_ce, pixel_column, pixel_row, horiz_sync, vert_sync,
           video_on, line_start, frame_start, vblank, frame_count
  );
endinterface

// File: rtl/vga_timing_core.sv
// Parametrised display timing generator on sys_clk with an internal pixel
// clock-enable divider, delayed syncs/video_on and frame/line markers.
module vga_timing_core #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned COORD_W  = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  vga_timing_core_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
  } dly_t;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               pix_ce_q, pix_ce_d;
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]        frame_count_q, frame_count_d;
  dly_t               dly_q [PIPE_DLY];
  dly_t               dly_d [PIPE_DLY];

  logic hs_raw, vs_raw, vid_raw;
  logic line_wrap, frame_wrap;

  // Raw timing terms decoded from the undelayed counters
  always_comb begin
    hs_raw     = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_raw     = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    vid_raw    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    line_wrap  = pix_ce_q && (h_cnt_q == H_LAST);
    frame_wrap = line_wrap && (v_cnt_q == V_LAST);
  end

  // Next-state: divider, counters, frame counter and sync/video delay line
  always_comb begin
    div_cnt_d     = '0;
    pix_ce_d      = 1'b0;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_count_d = frame_count_q;
    dly_d         = dly_q;
    if (!vga.enable) begin
      // Soft reset; frame_count deliberately keeps its value
      h_cnt_d = '0;
      v_cnt_d = '0;
      for (int unsigned i = 0; i < PIPE_DLY; i++) dly_d[i] = '0;
    end else begin
      pix_ce_d  = (div_cnt_q == DIV_LAST);
      div_cnt_d = pix_ce_d ? '0 : div_cnt_q + 1'b1;
      if (pix_ce_q) begin
        h_cnt_d = line_wrap ? '0 : h_cnt_q + 1'b1;
        if (line_wrap) v_cnt_d = frame_wrap ? '0 : v_cnt_q + 1'b1;
        if (frame_wrap) frame_count_d = frame_count_q + 1'b1;
        for (int unsigned i = PIPE_DLY - 1; i > 0; i--) dly_d[i] = dly_q[i-1];
        dly_d[0] = '{hs: hs_raw, vs: vs_raw, vid: vid_raw};
      end
    end
  end

  // State registers with asynchronous reset to the idle/inactive values
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt_q     <= '0;
      pix_ce_q      <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_count_q <= '0;
      for (int unsigned i = 0; i < PIPE_DLY; i++) dly_q[i] <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_ce_q      <= pix_ce_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_count_q <= frame_count_d;
      for (int unsigned i = 0; i < PIPE_DLY; i++) dly_q[i] <= dly_d[i];
    end
  end

  assign vga.pix_ce       = pix_ce_q;
  assign vga.pixel_column = h_cnt_q;
  assign vga.pixel_row    = v_cnt_q;
  assign vga.horiz_sync   = dly_q[PIPE_DLY-1].hs ? HS_POL : ~HS_POL;
  assign vga.vert_sync    = dly_q[PIPE_DLY-1].vs ? VS_POL : ~VS_POL;
  assign vga.video_on     = dly_q[PIPE_DLY-1].vid;
  assign vga.line_start   = line_wrap;
  assign vga.frame_start  = frame_wrap;
  assign vga.vblank       = (v_cnt_q >= V_VIS);
  assign vga.frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench: default 640x480 timing (horizontal) and a tiny 12x7 mode
// (full frames, enable drop, frame counter wrap, async reset).
module tb_vga_timing_core;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_core_if #(.COORD_W(10)) ifa ();
  vga_timing_core_if #(.COORD_W(10)) ifb ();

  vga_timing_core #(.COORD_W(10)) u_a (
    .sys_clk (clk),
    .sys_rst (rst_a),
    .vga     (ifa)
  );

  vga_timing_core #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CLK_DIV  (1), .PIPE_DLY (1), .COORD_W (10)
  ) u_b (
    .sys_clk (clk),
    .sys_rst (rst_b),
    .vga     (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic pce, input logic [9:0] col,
                          input logic [9:0] row, input logic hs, input logic vs,
                          input logic vid, input logic ls, input logic fs, input logic vb);
    chk({tag, "_pce"}, 32'(pce), 0);
    chk({tag, "_col"}, 32'(col), 0);
    chk({tag, "_row"}, 32'(row), 0);
    chk({tag, "_hs"},  32'(hs),  1);
    chk({tag, "_vs"},  32'(vs),  1);
    chk({tag, "_vid"}, 32'(vid), 0);
    chk({tag, "_ls"},  32'(ls),  0);
    chk({tag, "_fs"},  32'(fs),  0);
    chk({tag, "_vb"},  32'(vb),  0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc, t, hs_lo, vid_n, ls_n, t656, t_hs, ls_cyc0, ls_cyc1, row800;
    int unsigned vs_lo, vb_n, fs_n, fc83, fs83, ls83;
    logic found;

    ifa.enable = 1'b1;
    ifb.enable = 1'b1;

    // ---------------- default mode: reset values ----------------
    @(negedge clk);
    chk_idle("a_rst", ifa.pix_ce, ifa.pixel_column, ifa.pixel_row, ifa.horiz_sync,
             ifa.vert_sync, ifa.video_on, ifa.line_start, ifa.frame_start, ifa.vblank);
    chk("a_rst_fc", 32'(ifa.frame_count), 0);
    rst_a = 1'b0;

    // first pix_ce CLK_DIV cycles after release, then period 4
    cyc = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); cyc++;
      if (ifa.pix_ce) found = 1'b1;
    end
    chk("a_first_ce", cyc, 4);
    chk("a_first_col", 32'(ifa.pixel_column), 0);

    // walk two lines of ticks; tick 0 is the current sample
    t = 0; cyc = 0; hs_lo = 0; vid_n = 0; ls_n = 0;
    t656 = 9999; t_hs = 9999; ls_cyc0 = 0; ls_cyc1 = 0; row800 = 9999;
    for (int i = 0; i < 8000 && t < 1602; i++) begin
      if (ifa.pix_ce) begin
        if (t < 800) begin
          if (!ifa.horiz_sync) hs_lo++;
          if (ifa.video_on) vid_n++;
          if (ifa.pixel_column == 10'd656) t656 = t;
          if (!ifa.horiz_sync && t_hs == 9999) t_hs = t;
        end
        if (t == 800) row800 = 32'(ifa.pixel_row);
        if (ifa.line_start) begin
          if (ls_n == 0) begin
            ls_cyc0 = cyc;
            chk("a_ls_col", 32'(ifa.pixel_column), 799);
          end else begin
            ls_cyc1 = cyc;
          end
          ls_n++;
        end
        t++;
      end
      @(negedge clk); cyc++;
    end
    chk("a_ticks", t, 1602);
    chk("a_hs_width", hs_lo, 96);
    chk("a_hs_delay", t_hs - t656, 2);
    chk("a_vid_width", vid_n, 640);
    chk("a_ls_count", ls_n, 2);
    chk("a_ls_period", ls_cyc1 - ls_cyc0, 3200);
    chk("a_row_after_wrap", row800, 1);

    // async reset mid-line, observed before the next edge
    repeat (10) @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk_idle("a_async", ifa.pix_ce, ifa.pixel_column, ifa.pixel_row, ifa.horiz_sync,
             ifa.vert_sync, ifa.video_on, ifa.line_start, ifa.frame_start, ifa.vblank);
    @(negedge clk);
    rst_a = 1'b0;
    cyc = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); cyc++;
      if (ifa.pix_ce) found = 1'b1;
    end
    chk("a_rst_first_ce", cyc, 4);
    chk("a_rst_col0", 32'(ifa.pixel_column), 0);
    repeat (4) @(negedge clk);
    chk("a_rst_col1", 32'(ifa.pixel_column), 1);
    chk("a_rst_row", 32'(ifa.pixel_row), 0);

    // ---------------- tiny mode: one full 84-tick frame ----------------
    chk_idle("b_rst", ifb.pix_ce, ifb.pixel_column, ifb.pixel_row, ifb.horiz_sync,
             ifb.vert_sync, ifb.video_on, ifb.line_start, ifb.frame_start, ifb.vblank);
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_first_ce", 32'(ifb.pix_ce), 1);
    vid_n = 0; hs_lo = 0; vs_lo = 0; vb_n = 0; ls_n = 0; fs_n = 0;
    fc83 = 99; fs83 = 0; ls83 = 0; cyc = 0;
    for (int k = 0; k < 85; k++) begin
      if (k > 0) @(negedge clk);
      if (ifb.pix_ce) cyc++;
      if (k < 84) begin
        if (ifb.video_on) vid_n++;
        if (!ifb.horiz_sync) hs_lo++;
        if (!ifb.vert_sync) vs_lo++;
        if (ifb.vblank) vb_n++;
        if (ifb.line_start) ls_n++;
        if (ifb.frame_start) fs_n++;
      end
      if (k == 83) begin
        fc83 = 32'(ifb.frame_count);
        fs83 = 32'(ifb.frame_start);
        ls83 = 32'(ifb.line_start);
      end
    end
    chk("b_ce_every", cyc, 85);
    chk("b_vid_ticks", vid_n, 32);
    chk("b_hs_ticks", hs_lo, 14);
    chk("b_vs_ticks", vs_lo, 12);
    chk("b_vblank_ticks", vb_n, 36);
    chk("b_ls_count", ls_n, 7);
    chk("b_fs_count", fs_n, 1);
    chk("b_fs_last", fs83, 1);
    chk("b_ls_with_fs", ls83, 1);
    chk("b_fc_before", fc83, 0);
    chk("b_fc_after", 32'(ifb.frame_count), 1);
    chk("b_wrap_col", 32'(ifb.pixel_column), 0);
    chk("b_wrap_row", 32'(ifb.pixel_row), 0);

    // enable drop at h=5 v=2 for 3 cycles
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (ifb.pixel_column == 10'd5 && ifb.pixel_row == 10'd2) found = 1'b1;
    end
    chk("b_find_h5v2", 32'(found), 1);
    ifb.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("b_en0", ifb.pix_ce, ifb.pixel_column, ifb.pixel_row, ifb.horiz_sync,
               ifb.vert_sync, ifb.video_on, ifb.line_start, ifb.frame_start, ifb.vblank);
      chk("b_en0_fc", 32'(ifb.frame_count), 1);
    end
    ifb.enable = 1'b1;
    @(negedge clk);
    chk("b_en1_ce", 32'(ifb.pix_ce), 1);
    chk("b_en1_col0", 32'(ifb.pixel_column), 0);
    @(negedge clk);
    chk("b_en1_col1", 32'(ifb.pixel_column), 1);

    // frame counter wrap 65535 -> 0
    force u_b.frame_count_q = 16'hFFFF;
    #1;
    release u_b.frame_count_q;
    @(negedge clk);
    chk("b_fc_preload", 32'(ifb.frame_count), 65535);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (ifb.frame_start) found = 1'b1;
    end
    chk("b_fc_fs_seen", 32'(found), 1);
    chk("b_fc_hold", 32'(ifb.frame_count), 65535);
    @(negedge clk);
    chk("b_fc_wrap", 32'(ifb.frame_count), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
